// File: rtl/xctcmsg_pkg.sv
// Shared types for the message unit: writeback payload layout and result source identifiers.
package xctcmsg_pkg;

    localparam int XLEN          = 32;
    localparam int PASSTHROUGH_W = 8;

    typedef logic [PASSTHROUGH_W-1:0] passthrough_t;

    typedef struct packed {
        logic [4:0]      register;
        logic [XLEN-1:0] value;
        passthrough_t    passthrough;
    } writeback_data_t;

    typedef enum logic {
        WRITEBACK_SOURCE_SEND = 1'b0,
        WRITEBACK_SOURCE_RECV = 1'b1
    } writeback_source_t;

endpackage

// File: rtl/writeback_slot.sv
// One-entry result holding register. The slot frees when granted and may refill on that same edge.
module writeback_slot
    import xctcmsg_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  writeback_data_t in_data,
    input  logic            grant,
    output logic            slot_valid,
    output writeback_data_t slot_data
);

    // Ready looks only at local state and the grant, never at in_valid.
    assign in_ready = !slot_valid || grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            slot_valid <= 1'b1;
        end else if (grant) begin
            slot_valid <= 1'b0;
        end
    end

    // NOTE: payload is only meaningful while slot_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            slot_data <= in_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Fans send and receive pipeline results back into a single registered writeback channel.
module writeback_arbiter
    import xctcmsg_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            send_writeback_arbiter_valid,
    output logic            writeback_arbiter_send_ready,
    input  writeback_data_t send_writeback_arbiter_data,
    input  logic            receive_writeback_arbiter_valid,
    output logic            writeback_arbiter_receive_ready,
    input  writeback_data_t receive_writeback_arbiter_data,
    output logic            writeback_arbiter_wb_valid,
    input  logic            wb_writeback_arbiter_ready,
    output writeback_data_t writeback_arbiter_wb_data,
    output logic            writeback_arbiter_last_grant
);

    logic              send_slot_valid, recv_slot_valid;
    writeback_data_t   send_slot_data, recv_slot_data;
    logic              grant_send, grant_recv;
    logic              out_valid, out_empty;
    writeback_data_t   out_data;
    writeback_source_t out_src, rr_last;

    writeback_slot u_send_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (send_writeback_arbiter_valid),
        .in_ready   (writeback_arbiter_send_ready),
        .in_data    (send_writeback_arbiter_data),
        .grant      (grant_send),
        .slot_valid (send_slot_valid),
        .slot_data  (send_slot_data)
    );

    writeback_slot u_recv_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (receive_writeback_arbiter_valid),
        .in_ready   (writeback_arbiter_receive_ready),
        .in_data    (receive_writeback_arbiter_data),
        .grant      (grant_recv),
        .slot_valid (recv_slot_valid),
        .slot_data  (recv_slot_data)
    );

    assign out_empty = !out_valid || wb_writeback_arbiter_ready;

    // NOTE: both grants get a default before any branch so no path leaves them unassigned (no latch).
    always_comb begin
        grant_send = 1'b0;
        grant_recv = 1'b0;
        if (out_empty) begin
            if (send_slot_valid && recv_slot_valid) begin
                if (ROUND_ROBIN && (rr_last == WRITEBACK_SOURCE_RECV)) begin
                    grant_send = 1'b1;
                end else begin
                    grant_recv = 1'b1;
                end
            end else begin
                grant_send = send_slot_valid;
                grant_recv = recv_slot_valid;
            end
        end
    end

    // rr_last resets to receive so the first contended grant goes to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rr_last   <= WRITEBACK_SOURCE_RECV;
        end else if (out_empty) begin
            out_valid <= grant_send || grant_recv;
            if (grant_send) begin
                rr_last <= WRITEBACK_SOURCE_SEND;
            end else if (grant_recv) begin
                rr_last <= WRITEBACK_SOURCE_RECV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant_send) begin
            out_data <= send_slot_data;
            out_src  <= WRITEBACK_SOURCE_SEND;
        end else if (grant_recv) begin
            out_data <= recv_slot_data;
            out_src  <= WRITEBACK_SOURCE_RECV;
        end
    end

    assign writeback_arbiter_wb_valid   = out_valid;
    assign writeback_arbiter_wb_data    = out_data;
    assign writeback_arbiter_last_grant = out_valid ? logic'(out_src) : logic'(rr_last);

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Return path of the message unit. It collects completed results from the send pipeline and the receive pipeline, buffers one result per source, and arbitrates them onto a single valid/ready channel into the core's writeback stage. It is the counterpart of request dispatch: requests fan out by target pipeline, and this block fans the results back in. It guarantees one result per cycle peak throughput and no loss or duplication under back-pressure.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin grant between sources; 0 = fixed priority with receive over send.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
send_writeback_arbiter_valid  in  1  send pipeline result valid
writeback_arbiter_send_ready  out  1  send slot can accept
send_writeback_arbiter_data  in  $bits(writeback_data_t)  send result {register, value, passthrough}
receive_writeback_arbiter_valid  in  1  receive pipeline result valid
writeback_arbiter_receive_ready  out  1  receive slot can accept
receive_writeback_arbiter_data  in  $bits(writeback_data_t)  receive result
writeback_arbiter_wb_valid  out  1  result presented to writeback
wb_writeback_arbiter_ready  in  1  writeback accepts
writeback_arbiter_wb_data  out  $bits(writeback_data_t)  selected result
writeback_arbiter_last_grant  out  1  source of the current output register: 0 = send, 1 = receive (debug/verification)

Behaviour:
- Single clock domain is clk. Reset is asynchronous, active-low on rst_n.
- State: per-source slot {slot_valid, slot_data}, an output register {out_valid, out_data, out_src}, and a round-robin pointer rr_last.
- Reset values: both slot_valid = 0, out_valid = 0, rr_last = 1 so the first tie grants send. Data registers are don't-care. All outputs derive from state, so after reset valid = 0, last_grant = 1 and both readies = 1.
- Input handshake: accept when valid && ready. ready = !slot_valid || slot granted this cycle (same-cycle refill allowed). ready must not depend combinationally on the same source's valid.
- Output handshake: drained when out_valid && wb ready. out_valid and out_data hold stable until drained. No combinational path exists from inputs to wb outputs.
- Output register can load when out_empty = !out_valid || wb ready.
- Grant, evaluated when out_empty:
  - Only one slot valid: grant it.
  - Both slots valid, ROUND_ROBIN = 1: grant the source != rr_last.
  - Both slots valid, ROUND_ROBIN = 0: grant receive.
  - On grant: out_data <= slot_data, out_src <= source, rr_last <= source, granted slot_valid cleared unless refilled the same cycle.
- Latency: input accepted at cycle N gives slot valid at N+1 and wb_valid at N+2 when uncontended and out is empty or draining.
- Throughput: 1 result per cycle aggregate; each source gets at least 1 of every 2 grants under contention (RR).
- Back-pressure: wb ready low holds everything. Both slots fill, then both readies drop.
- Simultaneous arrival on both inputs with empty state: both accepted. Send is output at N+2, receive at N+3 (rr_last = 1 after reset). The grant order must be consistent with rr_last.
- Ordering: per-source FIFO order is preserved. Cross-source order is not guaranteed.
- Reset mid-operation: all valids clear immediately (async). Buffered results are discarded and upstream must re-issue.
- last_grant = out_src, or rr_last when out_valid = 0.

Decomposition:
- xctcmsg_pkg: writeback_data_t {register: 5-bit register index, value: XLEN, passthrough: passthrough_t} and a writeback_source_t enum {WRITEBACK_SOURCE_SEND, WRITEBACK_SOURCE_RECV}.
- One sub-module, writeback_slot: a 1-entry holding register with a valid/ready handshake plus a grant-clear input, instantiated once per source. Arbitration and the output register stay in the top module.

Test Plan:
- Reset then single send result {rd = 5, value = 0xDEADBEEF} at cycle 0 with wb ready = 1 -> wb_valid at cycle 2 with the same data, last_grant = 0. Send ready stays 1 throughout.
- Both inputs valid at cycle 0 (send rd = 1, recv rd = 2), ROUND_ROBIN = 1 -> rd = 1 at cycle 2, rd = 2 at cycle 3. Both readies are 1 at cycle 0.
- wb ready = 0 with continuous valids on both inputs -> exactly 3 results absorbed (2 slots + out). Both readies go to 0 and wb_data stays stable. Releasing ready drains them in grant order with no loss or duplicates.
- Saturated both sources for 20 cycles with ROUND_ROBIN = 1 and ready = 1 -> strict send/recv alternation, 10 results each ±1, 1 result per cycle after fill. With ROUND_ROBIN = 0 -> all receive results first.
- rst_n asserted mid-stream while out_valid = 1 and both slots full -> wb_valid = 0 and readies = 1 immediately (asynchronously). After release, no stale result appears.
- Random valid/ready stimulus for 10k cycles -> per-source order preserved, count in = count out + occupancy, scoreboard matches.
